// File: rtl/med_pkg.sv
// med_pkg: shared widths, pixel type and sequencer states for the median feeder and engine
package med_pkg;
  localparam int TAILLE = 8;
  localparam int NMBR = 9;
  typedef logic [TAILLE-1:0] pixel_t;
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
endpackage

// File: rtl/med_line_buf.sv
// med_line_buf: one image line of pixels, combinational read and write at the same address
module med_line_buf #(
  parameter int W  = 8,
  parameter int D  = 16,
  parameter int AW = $clog2(D)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wd,
  output logic [W-1:0]  rd
);
  logic [W-1:0] mem [D];
  always_ff @(posedge CLK)
    if (we) mem[addr] <= wd;
  assign rd = mem[addr];
endmodule

// File: rtl/med_win_feeder.sv
// med_win_feeder: builds 3x3 windows from a raster stream, feeds them serially to the median engine
module med_win_feeder #(
  parameter int TAILLE  = med_pkg::TAILLE,
  parameter int LARGEUR = 16,
  parameter int NMBR    = med_pkg::NMBR
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              SOF,
  input  logic [TAILLE-1:0] PIX_DI,
  input  logic              PIX_VALID,
  output logic              PIX_READY,
  output logic [TAILLE-1:0] MED_DI,
  output logic              MED_DSI,
  input  logic [TAILLE-1:0] MED_DO,
  input  logic              MED_DSO,
  output logic [TAILLE-1:0] PIX_DO,
  output logic              PIX_DSO
);
  import med_pkg::*;
  localparam int CW = $clog2(LARGEUR);
  state_t state, state_nx;
  logic [CW-1:0] col, col_a;
  logic [1:0] row, row_a;
  logic [3:0] k;
  logic [TAILLE-1:0] win [NMBR];
  logic [TAILLE-1:0] win_nx [NMBR];
  logic [TAILLE-1:0] lb0_rd, lb1_rd;
  logic acc, wrap, full;
  assign PIX_READY = state == IDLE;
  assign acc = PIX_VALID && PIX_READY;
  // SOF overrides the position of the pixel it qualifies
  assign col_a = SOF ? '0 : col;
  assign row_a = SOF ? '0 : row;
  assign wrap = col_a == CW'(LARGEUR - 1);
  assign full = row_a == 2'd2 && col_a >= CW'(2);
  med_line_buf #(.W(TAILLE), .D(LARGEUR)) u_lb0 (
    .CLK(CLK), .we(acc), .addr(col_a), .wd(PIX_DI), .rd(lb0_rd)
  );
  med_line_buf #(.W(TAILLE), .D(LARGEUR)) u_lb1 (
    .CLK(CLK), .we(acc), .addr(col_a), .wd(lb0_rd), .rd(lb1_rd)
  );
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win_nx[3*i]   = win[3*i+1];
      win_nx[3*i+1] = win[3*i+2];
      win_nx[3*i+2] = i == 0 ? lb1_rd : i == 1 ? lb0_rd : PIX_DI;
    end
  end
  always_comb
    state_nx = (state == IDLE && acc && full) ? SEND :
               (state == SEND && k == 4'(NMBR)) ? WAIT :
               (state == WAIT && MED_DSO) ? IDLE : state;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge CLK)
    if (acc) win <= win_nx;
  // first window pixel leaves on the accept edge so DSI starts the very next cycle
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      col <= '0;
      row <= '0;
      k <= '0;
      MED_DSI <= 1'b0;
      MED_DI <= '0;
      PIX_DSO <= 1'b0;
      PIX_DO <= '0;
    end else begin
      PIX_DSO <= 1'b0;
      if (acc) begin
        col <= wrap ? '0 : col_a + CW'(1);
        row <= (wrap && row_a != 2'd2) ? row_a + 2'd1 : row_a;
        if (full) begin
          MED_DSI <= 1'b1;
          MED_DI <= win_nx[0];
          k <= 4'd1;
        end
      end
      if (state == SEND) begin
        if (k == 4'(NMBR)) begin
          MED_DSI <= 1'b0;
          k <= '0;
        end else begin
          MED_DI <= win[k];
          k <= k + 4'd1;
        end
      end
      if (state == WAIT && MED_DSO) begin
        PIX_DO <= MED_DO;
        PIX_DSO <= 1'b1;
      end
    end
endmodule

// File: tb/tb_med_win_feeder.sv
// tb_med_win_feeder: scoreboard bench for the median window feeder with a behavioural median engine
module tb_med_win_feeder;
  logic CLK, nRST, SOF, PIX_VALID, PIX_READY, MED_DSI, MED_DSO, PIX_DSO;
  logic [7:0] PIX_DI, MED_DI, MED_DO, PIX_DO;
  logic eng_dso, spur_dso;
  logic [7:0] eng_do;
  logic [7:0] di_q[$];
  logic [7:0] out_q[$];
  logic [7:0] eb [9];
  int tests = 0, fails = 0, pulses = 0, cnt = 0, wt = 0;

  med_win_feeder #(.TAILLE(8), .LARGEUR(4)) dut (
    .CLK(CLK), .nRST(nRST), .SOF(SOF), .PIX_DI(PIX_DI), .PIX_VALID(PIX_VALID),
    .PIX_READY(PIX_READY), .MED_DI(MED_DI), .MED_DSI(MED_DSI), .MED_DO(MED_DO),
    .MED_DSO(MED_DSO), .PIX_DO(PIX_DO), .PIX_DSO(PIX_DSO)
  );

  assign MED_DSO = eng_dso | spur_dso;
  assign MED_DO = spur_dso ? 8'd77 : eng_do;

  initial CLK = 0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] med9(input logic [7:0] a [9]);
    logic [7:0] s [9];
    logic [7:0] t;
    s = a;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    return s[4];
  endfunction

  // engine model: collects 9 DSI pixels, answers with the median 3 cycles later
  initial begin
    eng_dso = 0; eng_do = 0;
    forever begin
      @(negedge CLK);
      eng_dso = 0;
      if (!nRST) begin
        cnt = 0; wt = 0;
      end else if (MED_DSI) begin
        eb[cnt] = MED_DI;
        cnt++;
        if (cnt == 9) begin
          eng_do = med9(eb); cnt = 0; wt = 3;
        end
      end else if (wt > 0) begin
        wt--;
        if (wt == 0) eng_dso = 1;
      end
    end
  end

  // monitor: compares every presented window pixel and filtered output against the queues
  initial forever begin
    @(negedge CLK);
    if (MED_DSI) begin
      if (di_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL med_di: unexpected window pixel %0d, none required", MED_DI);
      end else chk("med_di", int'(MED_DI), int'(di_q.pop_front()));
    end
    if (PIX_DSO) begin
      pulses++;
      if (out_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL pix_do: unexpected output %0d, none required", PIX_DO);
      end else chk("pix_do", int'(PIX_DO), int'(out_q.pop_front()));
    end
  end

  task automatic push_win(input int v);
    int offs [9] = '{-5, -4, -3, -1, 0, 1, 3, 4, 5};
    foreach (offs[i]) di_q.push_back(8'(v + offs[i]));
    out_q.push_back(8'(v));
  endtask

  task automatic pix(input logic [7:0] v, input logic sof, input int exp_stall);
    int st = 0;
    @(negedge CLK);
    PIX_DI = v; SOF = sof; PIX_VALID = 1;
    while (!PIX_READY && st < 100) begin
      st++;
      @(negedge CLK);
    end
    chk("stall", st, exp_stall);
    if (st > 0) chk("dso_at_ready", int'(PIX_DSO), 1);
    @(posedge CLK);
  endtask

  task automatic drain();
    int n = 0;
    while (out_q.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("drain", out_q.size(), 0);
  endtask

  task automatic frame(input logic sof0);
    for (int i = 0; i < 16; i++) begin
      if (i == 10 || i == 11 || i == 14 || i == 15) push_win(i - 5);
      pix(8'(i), i == 0 && sof0, (i == 11 || i == 12 || i == 15) ? 12 : 0);
    end
    @(negedge CLK);
    PIX_VALID = 0; SOF = 0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nRST = 1; SOF = 0; PIX_DI = 0; PIX_VALID = 0; spur_dso = 0;
    #2 nRST = 0;
    repeat (2) @(negedge CLK);
    chk("rst_ready", int'(PIX_READY), 1);
    chk("rst_dsi", int'(MED_DSI), 0);
    chk("rst_di", int'(MED_DI), 0);
    chk("rst_dso", int'(PIX_DSO), 0);
    chk("rst_do", int'(PIX_DO), 0);
    nRST = 1;
    frame(1);
    chk("idle_ready", int'(PIX_READY), 1);
    for (int i = 0; i < 6; i++) pix(8'(200 + i), i == 0, 0);
    frame(1);
    for (int i = 0; i < 10; i++) pix(8'(i), i == 0, 0);
    di_q.push_back(8'd0); di_q.push_back(8'd1); di_q.push_back(8'd2); di_q.push_back(8'd4);
    pix(8'd10, 0, 0);
    repeat (4) @(negedge CLK);
    #2 nRST = 0; PIX_VALID = 0;
    #1;
    chk("abort_ready", int'(PIX_READY), 1);
    chk("abort_dsi", int'(MED_DSI), 0);
    chk("abort_dso", int'(PIX_DSO), 0);
    chk("abort_do", int'(PIX_DO), 0);
    chk("abort_di_q", di_q.size(), 0);
    repeat (2) @(negedge CLK);
    nRST = 1;
    frame(0);
    @(negedge CLK); spur_dso = 1;
    @(negedge CLK); spur_dso = 0;
    repeat (3) @(negedge CLK);
    chk("pulses", pulses, 12);
    chk("di_q_empty", di_q.size(), 0);
    chk("out_q_empty", out_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/med_win_feeder.md
Name: med_win_feeder

Overview:
Feeds the 9-pixel median engine from a raster pixel stream. Buffers two image lines and assembles a 3x3 window for every interior pixel. Streams each window serially to the engine on its DI/DSI input, waits for the engine's DO/DSO result, and emits the filtered pixel downstream. Sits between the video/pixel source and the median engine wrapper; this block is the transmitter side of the engine's DSI/DI interface.

Parameters:
TAILLE, 8, pixel width in bits
LARGEUR, 16, image line width in pixels (>=3)
NMBR, 9, pixels per window (fixed 9; not for override)

Ports:
CLK  in  1  clock, all state on rising edge
nRST  in  1  asynchronous active-low reset
SOF  in  1  start of frame; qualifies the accepted pixel as (row 0, col 0)
PIX_DI  in  TAILLE  input pixel, raster order
PIX_VALID  in  1  PIX_DI valid
PIX_READY  out  1  block can accept; pixel accepted when PIX_VALID && PIX_READY
MED_DI  out  TAILLE  window pixel to engine
MED_DSI  out  1  MED_DI valid; high exactly 9 consecutive cycles per window
MED_DO  in  TAILLE  engine result
MED_DSO  in  1  engine result valid (single-cycle pulse)
PIX_DO  out  TAILLE  filtered pixel
PIX_DSO  out  1  PIX_DO valid, single-cycle pulse; no backpressure

Behaviour:
- Reset, async on nRST low: state IDLE, col=0, row=0, k=0. MED_DSI=0, MED_DI=0, PIX_DSO=0, PIX_DO=0, PIX_READY=1. Line buffers and window are not reset; their contents are irrelevant until valid.
- PIX_READY = (state==IDLE), combinational.
- Accept at (row,col), with SOF=1 forcing row=col=0 for this pixel:
  - new column = {top=LB1[col], mid=LB0[col], bot=PIX_DI}
  - LB1[col]<=LB0[col]; LB0[col]<=PIX_DI
  - window shifts left one column; new column enters at right
  - col increments; at LARGEUR-1 it wraps to 0 and row increments
  - row saturates at 2; only row>=2 matters
- Window complete when row>=2 and col>=2 for the accepted pixel: IDLE->SEND on the next edge. Otherwise stay IDLE.
- SEND: for 9 cycles, k=0..8: MED_DSI=1 and MED_DI=window[k], row-major from top-left to bottom-right. MED_DI/MED_DSI are registered. The first DSI cycle is the cycle after acceptance. After k=8, go to WAIT and drop MED_DSI.
- WAIT: on MED_DSO=1, PIX_DO<=MED_DO and PIX_DSO=1 for one cycle. State returns to IDLE on the same edge, so PIX_READY=1 in the PIX_DSO cycle.
- MED_DSO sampled in IDLE or SEND: ignored.
- No timeout in WAIT; the engine is required to answer.
- Output image is (rows-2) x (LARGEUR-2) interior pixels; borders produce no output.
- SOF can only be accepted in IDLE, so a frame restart mid-window is impossible. SOF simply restarts the counters.
- Missing SOF after reset: the first pixel is treated as (0,0).
- Reset mid-SEND or mid-WAIT: MED_DSI drops asynchronously and the window is abandoned. The engine is reset by the same nRST.
- Throughput per interior pixel: 1 accept + 9 SEND + engine latency L + 1 cycle.

Decomposition:
- Package med_pkg holds:
  - TAILLE default and NMBR=9
  - pixel_t = logic [TAILLE-1:0]
  - state_t enum {IDLE, SEND, WAIT}
- The engine may import med_pkg as well.
- Sub-module med_line_buf: LARGEUR x TAILLE register array, one combinational read and one write at the same address per accept. It is instantiated twice (LB0, LB1).

Test Plan:
Use LARGEUR=4 and a bench engine model that pulses MED_DSO 3 cycles after the 9th DSI with the true median.
- nRST low mid-run -> PIX_READY=1, MED_DSI=0, PIX_DSO=0, PIX_DO=0 immediately.
- 4x4 frame, PIX_DI=row*4+col, SOF on pixel 0, PIX_VALID always high:
  - after pixel 10 is accepted -> MED_DI sequence 0,1,2,4,5,6,8,9,10
  - PIX_DO outputs in order 5,6,9,10; exactly 4 PIX_DSO pulses
- Same frame -> PIX_READY low from the cycle after pixel 10 is accepted until the PIX_DSO cycle; no input pixel lost or duplicated; pixel 11 accepted in the PIX_DSO cycle.
- Row wrap -> no MED_DSI after pixels 12 and 13 (col 0,1 of row 3); SEND after pixel 14.
- SOF reasserted on the 7th pixel -> counters restart; the next window starts only at the new (2,2) pixel and uses new-frame data only.
- nRST pulsed at SEND k=4 -> MED_DSI=0 at once. After release, a full 4x4 frame gives 5,6,9,10. A spurious MED_DSO in IDLE gives no PIX_DSO.
